// File: rtl/gelato_types.sv
// Shared types and default sizing for the gelato warp PC table.
package gelato_types;

  localparam int unsigned WARP_NUM_DEF        = 32;
  localparam int unsigned PC_WIDTH_DEF        = 32;
  localparam int unsigned SPLIT_NUM_WIDTH_DEF = 5;

  typedef logic [$clog2(WARP_NUM_DEF)-1:0] warp_num_t;
  typedef logic [PC_WIDTH_DEF-1:0]         addr_t;
  typedef logic [SPLIT_NUM_WIDTH_DEF-1:0]  split_num_t;

  typedef enum logic [1:0] {
    PC_FREE     = 2'd0,
    PC_READY    = 2'd1,
    PC_FETCHING = 2'd2
  } pc_state_e;

endpackage

// File: rtl/gelato_pc_slot.sv
// One warp slot: FREE/READY/FETCHING lifecycle plus PC and split-table index registers.
module gelato_pc_slot
  import gelato_types::*;
#(
  parameter int unsigned PcWidth    = PC_WIDTH_DEF,
  parameter int unsigned SplitWidth = SPLIT_NUM_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rdy,
  input  logic                  launch_hit,
  input  logic [PcWidth-1:0]    launch_pc,
  input  logic [SplitWidth-1:0] launch_split,
  input  logic                  sel_hit,
  input  logic                  upd_hit,
  input  logic [PcWidth-1:0]    upd_pc,
  input  logic [SplitWidth-1:0] upd_split,
  input  logic                  upd_exit,
  output pc_state_e             state,
  output logic [PcWidth-1:0]    pc,
  output logic [SplitWidth-1:0] split,
  output logic                  illegal
);

  pc_state_e             state_q, state_d;
  logic [PcWidth-1:0]    pc_q, pc_d;
  logic [SplitWidth-1:0] split_q, split_d;
  logic                  multi_hit;

  // The FSM allows at most one legal event per cycle, so any pairing is a protocol error.
  assign multi_hit = (launch_hit & sel_hit) | (launch_hit & upd_hit) | (sel_hit & upd_hit);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    split_d = split_q;
    illegal = 1'b0;
    if (multi_hit) begin
      illegal = 1'b1;
    end else if (launch_hit) begin
      if (state_q == PC_FREE) begin
        state_d = PC_READY;
        pc_d    = launch_pc;
        split_d = launch_split;
      end else begin
        illegal = 1'b1;
      end
    end else if (sel_hit) begin
      if (state_q == PC_READY) begin
        state_d = PC_FETCHING;
      end else begin
        illegal = 1'b1;
      end
    end else if (upd_hit) begin
      if (state_q == PC_FETCHING) begin
        if (upd_exit) begin
          state_d = PC_FREE;
        end else begin
          state_d = PC_READY;
          pc_d    = upd_pc;
          split_d = upd_split;
        end
      end else begin
        illegal = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= PC_FREE;
      pc_q    <= '0;
      split_q <= '0;
    end else if (rdy) begin
      state_q <= state_d;
      pc_q    <= pc_d;
      split_q <= split_d;
    end
  end

  assign state = state_q;
  assign pc    = pc_q;
  assign split = split_q;

endmodule

// File: rtl/gelato_pc_table.sv
// Per-warp PC table feeding the fetch scheduler: event decode, slot array, occupancy and error flag.
module gelato_pc_table
  import gelato_types::*;
#(
  parameter int unsigned WARP_NUM        = WARP_NUM_DEF,
  parameter int unsigned PC_WIDTH        = PC_WIDTH_DEF,
  parameter int unsigned SPLIT_NUM_WIDTH = SPLIT_NUM_WIDTH_DEF
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                rdy,
  output logic [WARP_NUM-1:0]                 pc_valid,
  output logic [WARP_NUM*PC_WIDTH-1:0]        pc_pc,
  output logic [WARP_NUM*SPLIT_NUM_WIDTH-1:0] pc_split_num,
  input  logic                                sel_valid,
  input  logic [$clog2(WARP_NUM)-1:0]         sel_warp,
  input  logic                                launch_valid,
  input  logic [$clog2(WARP_NUM)-1:0]         launch_warp,
  input  logic [PC_WIDTH-1:0]                 launch_pc,
  input  logic [SPLIT_NUM_WIDTH-1:0]          launch_split,
  output logic                                launch_ready,
  input  logic                                upd_valid,
  input  logic [$clog2(WARP_NUM)-1:0]         upd_warp,
  input  logic [PC_WIDTH-1:0]                 upd_pc,
  input  logic [SPLIT_NUM_WIDTH-1:0]          upd_split,
  input  logic                                upd_exit,
  output logic [$clog2(WARP_NUM):0]           active_count,
  output logic                                all_idle,
  output logic                                err_illegal
);

  localparam int unsigned WarpW = $clog2(WARP_NUM);
  localparam int unsigned CntW  = WarpW + 1;

  pc_state_e           slot_state [WARP_NUM];
  logic [WARP_NUM-1:0] slot_illegal;
  logic [CntW-1:0]     busy_cnt;
  logic                err_q;

  for (genvar g = 0; g < WARP_NUM; g++) begin : gen_slot
    gelato_pc_slot #(
      .PcWidth   (PC_WIDTH),
      .SplitWidth(SPLIT_NUM_WIDTH)
    ) u_slot (
      .clk         (clk),
      .rst_n       (rst_n),
      .rdy         (rdy),
      .launch_hit  (launch_valid && (launch_warp == WarpW'(g))),
      .launch_pc   (launch_pc),
      .launch_split(launch_split),
      .sel_hit     (sel_valid && (sel_warp == WarpW'(g))),
      .upd_hit     (upd_valid && (upd_warp == WarpW'(g))),
      .upd_pc      (upd_pc),
      .upd_split   (upd_split),
      .upd_exit    (upd_exit),
      .state       (slot_state[g]),
      .pc          (pc_pc[g*PC_WIDTH +: PC_WIDTH]),
      .split       (pc_split_num[g*SPLIT_NUM_WIDTH +: SPLIT_NUM_WIDTH]),
      .illegal     (slot_illegal[g])
    );

    assign pc_valid[g] = (slot_state[g] == PC_READY);
  end

  assign launch_ready = (slot_state[launch_warp] == PC_FREE);

  // Occupancy is derived from registered slot states, so launch/exit pairs net out naturally.
  always_comb begin
    busy_cnt = '0;
    for (int unsigned w = 0; w < WARP_NUM; w++) begin
      busy_cnt = busy_cnt + CntW'(slot_state[w] != PC_FREE);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (rdy) begin
      err_q <= err_q | (|slot_illegal);
    end
  end

  assign active_count = busy_cnt;
  assign all_idle     = (busy_cnt == '0);
  assign err_illegal  = err_q;

endmodule

// File: tb/tb_gelato_pc_table.sv
// Directed self-checking bench for gelato_pc_table.
module tb_gelato_pc_table;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          rdy;
  logic [31:0]   pc_valid;
  logic [1023:0] pc_pc;
  logic [159:0]  pc_split_num;
  logic          sel_valid;
  logic [4:0]    sel_warp;
  logic          launch_valid;
  logic [4:0]    launch_warp;
  logic [31:0]   launch_pc;
  logic [4:0]    launch_split;
  logic          launch_ready;
  logic          upd_valid;
  logic [4:0]    upd_warp;
  logic [31:0]   upd_pc;
  logic [4:0]    upd_split;
  logic          upd_exit;
  logic [5:0]    active_count;
  logic          all_idle;
  logic          err_illegal;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  gelato_pc_table dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rdy         (rdy),
    .pc_valid    (pc_valid),
    .pc_pc       (pc_pc),
    .pc_split_num(pc_split_num),
    .sel_valid   (sel_valid),
    .sel_warp    (sel_warp),
    .launch_valid(launch_valid),
    .launch_warp (launch_warp),
    .launch_pc   (launch_pc),
    .launch_split(launch_split),
    .launch_ready(launch_ready),
    .upd_valid   (upd_valid),
    .upd_warp    (upd_warp),
    .upd_pc      (upd_pc),
    .upd_split   (upd_split),
    .upd_exit    (upd_exit),
    .active_count(active_count),
    .all_idle    (all_idle),
    .err_illegal (err_illegal)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    sel_valid    = 1'b0;
    sel_warp     = '0;
    launch_valid = 1'b0;
    launch_warp  = '0;
    launch_pc    = '0;
    launch_split = '0;
    upd_valid    = 1'b0;
    upd_warp     = '0;
    upd_pc       = '0;
    upd_split    = '0;
    upd_exit     = 1'b0;
  endtask

  // Inputs change on the falling edge; outputs are sampled on the next falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic set_launch(input int w, input logic [31:0] pc, input logic [4:0] sp);
    launch_valid = 1'b1;
    launch_warp  = 5'(w);
    launch_pc    = pc;
    launch_split = sp;
  endtask

  task automatic set_sel(input int w);
    sel_valid = 1'b1;
    sel_warp  = 5'(w);
  endtask

  task automatic set_upd(input int w, input logic [31:0] pc, input logic [4:0] sp, input logic ex);
    upd_valid = 1'b1;
    upd_warp  = 5'(w);
    upd_pc    = pc;
    upd_split = sp;
    upd_exit  = ex;
  endtask

  initial begin
    clear_inputs();
    rdy   = 1'b1;
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_pc_valid", 64'(pc_valid), 64'h0);
    check("rst_active", 64'(active_count), 64'd0);
    check("rst_all_idle", 64'(all_idle), 64'd1);
    check("rst_err", 64'(err_illegal), 64'd0);
    check("rst_launch_ready", 64'(launch_ready), 64'd1);
    check("rst_pc3", 64'(pc_pc[3*32 +: 32]), 64'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Launch w3, then select and update it.
    set_launch(3, 32'h100, 5'd2);
    step();
    check("launch_pc_valid", 64'(pc_valid), 64'h8);
    check("launch_pc3", 64'(pc_pc[3*32 +: 32]), 64'h100);
    check("launch_split3", 64'(pc_split_num[3*5 +: 5]), 64'd2);
    check("launch_active", 64'(active_count), 64'd1);
    check("launch_all_idle", 64'(all_idle), 64'd0);
    launch_warp = 5'd3;
    #1;
    check("launch_ready_busy", 64'(launch_ready), 64'd0);
    clear_inputs();

    set_sel(3);
    step();
    check("sel_pc_valid", 64'(pc_valid), 64'h0);
    check("sel_pc3_kept", 64'(pc_pc[3*32 +: 32]), 64'h100);

    set_upd(3, 32'h104, 5'd1, 1'b0);
    step();
    check("upd_pc_valid", 64'(pc_valid), 64'h8);
    check("upd_pc3", 64'(pc_pc[3*32 +: 32]), 64'h104);
    check("upd_split3", 64'(pc_split_num[3*5 +: 5]), 64'd1);

    // Put w5 into FETCHING, then fire three events on distinct slots together.
    set_launch(5, 32'h500, 5'd0);
    step();
    set_sel(5);
    step();
    check("w5_fetching_valid", 64'(pc_valid), 64'h8);
    check("w5_active", 64'(active_count), 64'd2);
    set_launch(0, 32'h40, 5'd3);
    set_sel(3);
    set_upd(5, 32'hdead, 5'd7, 1'b1);
    step();
    check("multi_pc_valid", 64'(pc_valid), 64'h1);
    check("multi_active", 64'(active_count), 64'd2);
    check("multi_pc0", 64'(pc_pc[0 +: 32]), 64'h40);
    check("multi_pc5_kept", 64'(pc_pc[5*32 +: 32]), 64'h500);
    check("multi_err", 64'(err_illegal), 64'd0);

    // Illegal: select a FREE slot, launch a READY slot.
    set_sel(7);
    set_launch(0, 32'h999, 5'd9);
    step();
    check("illegal_pc_valid", 64'(pc_valid), 64'h1);
    check("illegal_pc0", 64'(pc_pc[0 +: 32]), 64'h40);
    check("illegal_err", 64'(err_illegal), 64'd1);
    step();
    check("illegal_err_sticky", 64'(err_illegal), 64'd1);

    // Two events on the same FETCHING slot: neither applies.
    set_sel(3);
    set_upd(3, 32'h200, 5'd4, 1'b0);
    step();
    check("same_slot_pc_valid", 64'(pc_valid), 64'h1);
    check("same_slot_pc3", 64'(pc_pc[3*32 +: 32]), 64'h104);

    // rdy low freezes everything.
    rdy = 1'b0;
    set_launch(1, 32'h11, 5'd1);
    @(posedge clk);
    @(negedge clk);
    check("hold_pc_valid", 64'(pc_valid), 64'h1);
    check("hold_active", 64'(active_count), 64'd2);
    rdy = 1'b1;
    step();
    check("resume_pc_valid", 64'(pc_valid), 64'h3);
    check("resume_active", 64'(active_count), 64'd3);
    check("resume_pc1", 64'(pc_pc[1*32 +: 32]), 64'h11);

    // Clean restart, then fill and drain every slot.
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    @(negedge clk);
    for (int w = 0; w < 32; w++) begin
      set_launch(w, 32'(w * 4), 5'(w));
      step();
    end
    check("full_active", 64'(active_count), 64'd32);
    check("full_pc_valid", 64'(pc_valid), 64'hffff_ffff);
    check("full_pc17", 64'(pc_pc[17*32 +: 32]), 64'h44);
    check("full_split17", 64'(pc_split_num[17*5 +: 5]), 64'd17);
    for (int w = 0; w < 32; w++) begin
      set_sel(w);
      step();
    end
    check("all_sel_pc_valid", 64'(pc_valid), 64'h0);
    check("all_sel_active", 64'(active_count), 64'd32);
    for (int w = 0; w < 32; w++) begin
      set_upd(w, 32'h0, 5'd0, 1'b1);
      step();
    end
    check("drain_active", 64'(active_count), 64'd0);
    check("drain_all_idle", 64'(all_idle), 64'd1);
    check("drain_err", 64'(err_illegal), 64'd0);

    // Stale update on a FREE slot.
    set_upd(2, 32'h8, 5'd0, 1'b0);
    step();
    check("stale_err", 64'(err_illegal), 64'd1);
    check("stale_active", 64'(active_count), 64'd0);

    // Asynchronous reset in the middle of a cycle.
    set_launch(9, 32'h900, 5'd5);
    step();
    check("pre_rst_pc_valid", 64'(pc_valid), 64'h200);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_pc_valid", 64'(pc_valid), 64'h0);
    check("async_active", 64'(active_count), 64'd0);
    check("async_all_idle", 64'(all_idle), 64'd1);
    check("async_err", 64'(err_illegal), 64'd0);
    check("async_pc9", 64'(pc_pc[9*32 +: 32]), 64'h0);
    rst_n = 1'b1;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
